// File: rtl/qec_grid_sequencer_pkg.sv
// qec_grid_sequencer_pkg
// Shared definitions for the stabilizer-grid sequencer:
//   - sequencer state encoding (8 states, 3 bits)
//   - default coordinate / match-word widths
//   - grid index -> (y, x) conversion helpers (index i = y*GRID_WIDTH + x)
package qec_grid_sequencer_pkg;

  localparam int CORDINATE_WIDTH_DEFAULT   = 4;
  localparam int MATCH_VALUE_WIDTH_DEFAULT = 2 * CORDINATE_WIDTH_DEFAULT;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_LOAD    = 3'd1,
    ST_SETTLE  = 3'd2,
    ST_START   = 3'd3,
    ST_OFFER   = 3'd4,
    ST_STOP    = 3'd5,
    ST_CAPTURE = 3'd6,
    ST_DRAIN   = 3'd7
  } seq_state_t;

  // Row of a flattened grid index.
  function automatic int idx_to_y(input int idx, input int width);
    return idx / width;
  endfunction

  // Column of a flattened grid index.
  function automatic int idx_to_x(input int idx, input int width);
    return idx % width;
  endfunction

endpackage

// File: rtl/qec_grid_sequencer_lowest_set_encoder.sv
// lowest_set_encoder
// N-bit priority encoder: returns the index of the lowest set bit of vec.
// Ports:
//   vec   in  N   : input vector
//   index out IW  : index of the lowest set bit (0 when none)
//   none  out 1   : high when vec is all zeros
module lowest_set_encoder #(
  parameter int N  = 6,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  vec,
  output logic [IW-1:0] index,
  output logic          none
);

  // Scan from the top down so the lowest set bit is the last one to win.
  always_comb begin
    index = '0;
    none  = 1'b1;
    for (int i = N - 1; i >= 0; i--) begin
      index = vec[i] ? IW'(i) : index;
      none  = none & ~vec[i];
    end
  end

endmodule

// File: rtl/qec_grid_sequencer.sv
// qec_grid_sequencer
// Control-side driver for the stabilizer decoder grid. Accepts one syndrome
// word, loads it into the grid with a one-cycle pulse, runs the offer phase
// with start/stop pulses separated by fixed cycle budgets, captures the grid's
// match values and streams one result per defect over a valid/ready port.
// Ports:
//   clk, reset               : clock, asynchronous active-high reset
//   syndrome_in/valid/ready  : syndrome input handshake (ready only in IDLE)
//   measurement_value_out    : registered copy of the accepted syndrome
//   measurement_valid_out    : one-cycle grid load pulse
//   start_offer, stop_offer  : one-cycle offer-phase pulses
//   match_value_in           : grid match values, slice i = [i*MW +: MW]
//   result_valid/ready       : result output handshake
//   result_y/x/match/last    : defect coordinates, its match, final-defect flag
//   done                     : one-cycle end-of-round pulse
//   busy                     : high in every state except IDLE
module qec_grid_sequencer
  import qec_grid_sequencer_pkg::*;
#(
  parameter int GRID_HEIGHT       = 2,
  parameter int GRID_WIDTH        = 3,
  parameter int CORDINATE_WIDTH   = CORDINATE_WIDTH_DEFAULT,
  parameter int MATCH_VALUE_WIDTH = 2 * CORDINATE_WIDTH,
  parameter int SETTLE_CYCLES     = 100,
  parameter int OFFER_CYCLES      = 2500
) (
  input  logic                                              clk,
  input  logic                                              reset,
  input  logic [GRID_HEIGHT*GRID_WIDTH-1:0]                 syndrome_in,
  input  logic                                              syndrome_valid,
  output logic                                              syndrome_ready,
  output logic [GRID_HEIGHT*GRID_WIDTH-1:0]                 measurement_value_out,
  output logic                                              measurement_valid_out,
  output logic                                              start_offer,
  output logic                                              stop_offer,
  input  logic [GRID_HEIGHT*GRID_WIDTH*MATCH_VALUE_WIDTH-1:0] match_value_in,
  output logic                                              result_valid,
  input  logic                                              result_ready,
  output logic [CORDINATE_WIDTH-1:0]                        result_y,
  output logic [CORDINATE_WIDTH-1:0]                        result_x,
  output logic [MATCH_VALUE_WIDTH-1:0]                      result_match,
  output logic                                              result_last,
  output logic                                              done,
  output logic                                              busy
);

  localparam int N       = GRID_HEIGHT * GRID_WIDTH;
  localparam int MW      = MATCH_VALUE_WIDTH;
  localparam int IW      = (N > 1) ? $clog2(N) : 1;
  localparam int CNT_MAX = (SETTLE_CYCLES > OFFER_CYCLES) ? SETTLE_CYCLES : OFFER_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  seq_state_t          state_r;
  logic [CNT_W-1:0]    cnt_r;
  logic [N-1:0]        pending_r;
  logic [N*MW-1:0]     match_r;

  logic [IW-1:0]       enc_index_s;
  logic                enc_none_s;
  logic                drain_s;
  logic                hs_s;
  logic                last_s;
  logic [N-1:0]        onehot_s;

  lowest_set_encoder #(.N(N), .IW(IW)) u_lowest_set_encoder (
    .vec   (pending_r),
    .index (enc_index_s),
    .none  (enc_none_s)
  );

  // Result port: decoded combinationally from the pending mask and captured matches.
  always_comb begin
    drain_s      = (state_r == ST_DRAIN);
    result_valid = drain_s & ~enc_none_s;
    hs_s         = result_valid & result_ready;
    onehot_s     = N'(1) << enc_index_s;
    // Exactly one bit left: clearing the lowest set bit leaves nothing.
    last_s       = result_valid & ((pending_r & (pending_r - N'(1))) == '0);
    result_last  = last_s;
    result_y     = drain_s ? CORDINATE_WIDTH'(idx_to_y(32'(enc_index_s), GRID_WIDTH)) : '0;
    result_x     = drain_s ? CORDINATE_WIDTH'(idx_to_x(32'(enc_index_s), GRID_WIDTH)) : '0;
    result_match = drain_s ? match_r[enc_index_s*MW +: MW] : '0;
  end

  // Round sequencer: state, shared down-counter, pending mask and all registered outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r               <= ST_IDLE;
      cnt_r                 <= '0;
      pending_r             <= '0;
      match_r               <= '0;
      measurement_value_out <= '0;
      measurement_valid_out <= 1'b0;
      start_offer           <= 1'b0;
      stop_offer            <= 1'b0;
      done                  <= 1'b0;
      syndrome_ready        <= 1'b1;
      busy                  <= 1'b0;
    end else begin
      // Pulse outputs default low; the states below raise them for one cycle.
      measurement_valid_out <= 1'b0;
      start_offer           <= 1'b0;
      stop_offer            <= 1'b0;
      done                  <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          // syndrome_ready is high throughout IDLE, so valid alone completes the handshake.
          if (syndrome_valid) begin
            measurement_value_out <= syndrome_in;
            pending_r             <= syndrome_in;
            measurement_valid_out <= 1'b1;
            syndrome_ready        <= 1'b0;
            busy                  <= 1'b1;
            state_r               <= ST_LOAD;
          end
        end
        ST_LOAD: begin
          cnt_r   <= CNT_W'(SETTLE_CYCLES);
          state_r <= ST_SETTLE;
        end
        ST_SETTLE: begin
          if (cnt_r == CNT_W'(1)) begin
            cnt_r       <= '0;
            start_offer <= 1'b1;
            state_r     <= ST_START;
          end else begin
            cnt_r <= cnt_r - CNT_W'(1);
          end
        end
        ST_START: begin
          cnt_r   <= CNT_W'(OFFER_CYCLES);
          state_r <= ST_OFFER;
        end
        ST_OFFER: begin
          if (cnt_r == CNT_W'(1)) begin
            cnt_r      <= '0;
            stop_offer <= 1'b1;
            state_r    <= ST_STOP;
          end else begin
            cnt_r <= cnt_r - CNT_W'(1);
          end
        end
        ST_STOP: begin
          state_r <= ST_CAPTURE;
        end
        ST_CAPTURE: begin
          match_r <= match_value_in;
          // An empty round has nothing to drain: done lands in the first DRAIN cycle.
          done    <= (pending_r == '0);
          state_r <= ST_DRAIN;
        end
        ST_DRAIN: begin
          if (enc_none_s) begin
            syndrome_ready <= 1'b1;
            busy           <= 1'b0;
            state_r        <= ST_IDLE;
          end else if (hs_s) begin
            pending_r <= pending_r & ~onehot_s;
            done      <= last_s;
          end
        end
        default: begin
          pending_r      <= '0;
          syndrome_ready <= 1'b1;
          busy           <= 1'b0;
          state_r        <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_qec_grid_sequencer.sv
// tb_qec_grid_sequencer
// Randomized scoreboard bench for qec_grid_sequencer (2x3 grid, S=100, O=2500).
// The driver pushes expected pulses and per-defect results when a syndrome is
// accepted; a negedge monitor pops and compares whenever the DUT presents them.
module tb_qec_grid_sequencer;

  localparam int GH = 2;
  localparam int GW = 3;
  localparam int CW = 4;
  localparam int MW = 8;
  localparam int S  = 100;
  localparam int O  = 2500;
  localparam int N  = GH * GW;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic [N-1:0]      syndrome_in = '0;
  logic              syndrome_valid = 1'b0;
  logic              syndrome_ready;
  logic [N-1:0]      measurement_value_out;
  logic              measurement_valid_out;
  logic              start_offer;
  logic              stop_offer;
  logic [N*MW-1:0]   match_value_in = '0;
  logic              result_valid;
  logic              result_ready = 1'b1;
  logic [CW-1:0]     result_y;
  logic [CW-1:0]     result_x;
  logic [MW-1:0]     result_match;
  logic              result_last;
  logic              done;
  logic              busy;

  qec_grid_sequencer #(
    .GRID_HEIGHT(GH), .GRID_WIDTH(GW), .CORDINATE_WIDTH(CW),
    .MATCH_VALUE_WIDTH(MW), .SETTLE_CYCLES(S), .OFFER_CYCLES(O)
  ) dut (
    .clk(clk), .reset(reset),
    .syndrome_in(syndrome_in), .syndrome_valid(syndrome_valid), .syndrome_ready(syndrome_ready),
    .measurement_value_out(measurement_value_out), .measurement_valid_out(measurement_valid_out),
    .start_offer(start_offer), .stop_offer(stop_offer), .match_value_in(match_value_in),
    .result_valid(result_valid), .result_ready(result_ready),
    .result_y(result_y), .result_x(result_x), .result_match(result_match),
    .result_last(result_last), .done(done), .busy(busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { int cyc; logic [N-1:0] syn; } mv_exp_t;
  typedef struct { logic [CW-1:0] y; logic [CW-1:0] x; logic [MW-1:0] m; logic last; } res_t;

  mv_exp_t mv_q[$];
  int      start_q[$];
  int      stop_q[$];
  int      done_q[$];
  res_t    res_q[$];

  int  total = 0;
  int  bad = 0;
  bit  done_seen = 1'b0;
  bit  derive_done = 1'b0;
  bit  rdy_rand = 1'b0;
  bit  ready_chk = 1'b0;
  bit  bp_hold = 1'b0;
  logic [2*CW+MW:0] bp_snap = '0;

  function automatic void chk(input bit ok, input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (!ok) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  function automatic logic [N*MW-1:0] rand_mv();
    logic [N*MW-1:0] v;
    for (int i = 0; i < N; i++) v[i*MW +: MW] = MW'($urandom);
    return v;
  endfunction

  // Monitor: compare pulses, results and backpressure stability against the queues.
  always @(negedge clk) begin
    mv_exp_t me;
    res_t    r;
    res_t    er;
    int      e;
    logic [2*CW+MW:0] cur;
    if (reset) begin
      bp_hold   = 1'b0;
      ready_chk = 1'b0;
    end else begin
      if (ready_chk) begin
        chk(syndrome_ready && !busy, "ready_after_done", 64'({syndrome_ready, busy}), 64'(2));
        ready_chk = 1'b0;
      end
      if (measurement_valid_out) begin
        if (mv_q.size() == 0) chk(1'b0, "mv_unexpected", 64'(1), 64'(0));
        else begin
          me = mv_q.pop_front();
          chk(cyc == me.cyc, "mv_cycle", 64'(cyc), 64'(me.cyc));
          chk(measurement_value_out == me.syn, "mv_value", 64'(measurement_value_out), 64'(me.syn));
        end
      end
      if (start_offer) begin
        if (start_q.size() == 0) chk(1'b0, "start_unexpected", 64'(1), 64'(0));
        else begin e = start_q.pop_front(); chk(cyc == e, "start_cycle", 64'(cyc), 64'(e)); end
      end
      if (stop_offer) begin
        if (stop_q.size() == 0) chk(1'b0, "stop_unexpected", 64'(1), 64'(0));
        else begin e = stop_q.pop_front(); chk(cyc == e, "stop_cycle", 64'(cyc), 64'(e)); end
      end
      if (done) begin
        if (done_q.size() == 0) chk(1'b0, "done_unexpected", 64'(1), 64'(0));
        else begin e = done_q.pop_front(); chk(cyc == e, "done_cycle", 64'(cyc), 64'(e)); end
        chk(!syndrome_ready, "ready_during_done", 64'(syndrome_ready), 64'(0));
        ready_chk = 1'b1;
        done_seen = 1'b1;
      end
      cur = {result_y, result_x, result_match, result_last};
      if (bp_hold) chk(result_valid && cur == bp_snap, "bp_stable", 64'({result_valid, cur}), 64'({1'b1, bp_snap}));
      if (result_valid) begin
        r = '{result_y, result_x, result_match, result_last};
        if (result_ready) begin
          bp_hold = 1'b0;
          if (res_q.size() == 0) chk(1'b0, "result_unexpected", 64'(cur), 64'(0));
          else begin
            er = res_q.pop_front();
            chk(r.y == er.y, "result_y", 64'(r.y), 64'(er.y));
            chk(r.x == er.x, "result_x", 64'(r.x), 64'(er.x));
            chk(r.m == er.m, "result_match", 64'(r.m), 64'(er.m));
            chk(r.last == er.last, "result_last", 64'(r.last), 64'(er.last));
            if (er.last && derive_done) done_q.push_back(cyc + 1);
          end
        end else begin
          bp_hold = 1'b1;
          bp_snap = cur;
        end
      end else begin
        bp_hold = 1'b0;
      end
    end
  end

  // Random consumer backpressure when enabled.
  initial begin
    forever begin
      @(posedge clk); #1;
      if (rdy_rand) result_ready = 1'($urandom_range(0, 1));
    end
  end

  task automatic check_idle_outputs(input string tag);
    chk(syndrome_ready == 1'b1, {tag, "_syndrome_ready"}, 64'(syndrome_ready), 64'(1));
    chk(busy == 1'b0, {tag, "_busy"}, 64'(busy), 64'(0));
    chk(measurement_value_out == '0, {tag, "_meas_value"}, 64'(measurement_value_out), 64'(0));
    chk({measurement_valid_out, start_offer, stop_offer, done} == 4'b0000, {tag, "_pulses"},
        64'({measurement_valid_out, start_offer, stop_offer, done}), 64'(0));
    chk({result_valid, result_y, result_x, result_match, result_last} == '0, {tag, "_result"},
        64'({result_valid, result_y, result_x, result_match, result_last}), 64'(0));
  endtask

  // Offer a syndrome, wait for acceptance and push every expectation for the round.
  task automatic accept(input logic [N-1:0] syn, input logic [N*MW-1:0] mv, input bit exact_done, output int t0);
    int guard = 0;
    int hi = -1;
    int pc = 0;
    res_t er;
    @(posedge clk); #1;
    match_value_in = mv;
    syndrome_in    = syn;
    syndrome_valid = 1'b1;
    done_seen      = 1'b0;
    @(negedge clk);
    while (!syndrome_ready && guard < 50) begin guard++; @(negedge clk); end
    chk(syndrome_ready, "accept_wait", 64'(syndrome_ready), 64'(1));
    t0 = cyc;
    mv_q.push_back('{t0 + 1, syn});
    start_q.push_back(t0 + S + 2);
    stop_q.push_back(t0 + S + O + 3);
    for (int i = 0; i < N; i++) if (syn[i]) begin hi = i; pc++; end
    for (int i = 0; i < N; i++) begin
      if (syn[i]) begin
        er = '{CW'(i / GW), CW'(i % GW), mv[i*MW +: MW], (i == hi)};
        res_q.push_back(er);
      end
    end
    derive_done = !exact_done;
    if (exact_done) done_q.push_back(t0 + S + O + 5 + pc);
    @(posedge clk); #1;
  endtask

  // mode 0: ready=1; 1: random ready; 2: ready low for first 5 DRAIN cycles; 3: valid held, data changing.
  task automatic run_round(input logic [N-1:0] syn, input logic [N*MW-1:0] mv, input int mode);
    int t0;
    int guard = 0;
    result_ready = (mode == 2) ? 1'b0 : 1'b1;
    rdy_rand     = (mode == 1);
    accept(syn, mv, (mode == 0) || (mode == 3) || (syn == '0), t0);
    if (mode != 3) syndrome_valid = 1'b0;
    while (!done_seen && guard < S + O + 200) begin
      @(posedge clk); #1;
      guard++;
      if (mode == 3) syndrome_in = N'($urandom);
      if (mode == 2 && cyc >= t0 + S + O + 10) result_ready = 1'b1;
    end
    chk(done_seen, "round_done", 64'(done_seen), 64'(1));
    syndrome_valid = 1'b0;
    rdy_rand       = 1'b0;
    result_ready   = 1'b1;
    @(posedge clk); #1;
  endtask

  // Reset during OFFER: outputs clear at once, no stale pulses afterwards.
  task automatic reset_round(input logic [N-1:0] syn);
    int t0;
    int guard = 0;
    result_ready = 1'b1;
    accept(syn, rand_mv(), 1'b1, t0);
    syndrome_valid = 1'b0;
    while (cyc < t0 + 1000 && guard < 1100) begin @(posedge clk); #1; guard++; end
    reset = 1'b1;
    #1;
    check_idle_outputs("mid_reset");
    mv_q.delete(); start_q.delete(); stop_q.delete(); done_q.delete(); res_q.delete();
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    repeat (1700) @(posedge clk);
    #1;
  endtask

  logic [N*MW-1:0] mvv;

  initial begin
    repeat (3) @(posedge clk);
    #1;
    check_idle_outputs("reset");
    reset = 1'b0;

    mvv = rand_mv();
    mvv[0*MW +: MW] = 8'h01;
    mvv[1*MW +: MW] = 8'h00;
    run_round(6'b000011, mvv, 0);
    run_round(6'b000011, rand_mv(), 2);
    run_round(6'b000000, rand_mv(), 0);
    run_round(6'b111111, rand_mv(), 0);
    run_round(6'b100110, rand_mv(), 3);
    reset_round(6'b010101);
    run_round(6'b101101, rand_mv(), 0);
    for (int k = 0; k < 4; k++) run_round(N'($urandom), rand_mv(), 1);

    chk((mv_q.size() + start_q.size() + stop_q.size() + done_q.size() + res_q.size()) == 0, "queues_empty",
        64'(mv_q.size() + start_q.size() + stop_q.size() + done_q.size() + res_q.size()), 64'(0));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/qec_grid_sequencer.md
# qec_grid_sequencer

Control-side driver for the single-layer stabilizer decoder grid (default 2×3 X-stabilizer array). It accepts one syndrome word through a valid/ready handshake and loads it into the grid with a one-cycle `measurement_valid` pulse. It then runs the offer phase with `start_offer`/`stop_offer` pulses separated by a fixed cycle budget, captures every `match_value_out`, and streams one result per defect (coordinates plus match value) through a valid/ready output port. It replaces hand-timed bench stimulus and sits between the host/readout logic and the grid top.

## Interface
Parameters:
- `GRID_HEIGHT`, 2: stabilizer rows (y).
- `GRID_WIDTH`, 3: stabilizer columns (x).
- `CORDINATE_WIDTH`, 4: width of one coordinate.
- `MATCH_VALUE_WIDTH`, 2*CORDINATE_WIDTH: match word, {y, x}.
- `SETTLE_CYCLES`, 100: idle cycles between the load pulse and `start_offer`. Must be ≥1.
- `OFFER_CYCLES`, 2500: cycles between the `start_offer` cycle and the `stop_offer` cycle. Must be ≥1.

Ports (N = GRID_HEIGHT*GRID_WIDTH; index i = y*GRID_WIDTH + x):
- `clk` in 1: single clock, rising edge.
- `reset` in 1: asynchronous, active-high.
- `syndrome_in` in N: bit i is the defect flag of stabilizer (y, x).
- `syndrome_valid` in 1: syndrome offered.
- `syndrome_ready` out 1: high only in IDLE.
- `measurement_value_out` out N: registered copy of the accepted syndrome, to the grid `measurement_value_in_y_x`.
- `measurement_valid_out` out 1: one-cycle load pulse, fanned to all `measurement_valid_in_y_x`.
- `start_offer` out 1: one-cycle pulse.
- `stop_offer` out 1: one-cycle pulse.
- `match_value_in` in N*MATCH_VALUE_WIDTH: grid `match_value_out`; slice i is bits [i*MW +: MW].
- `result_valid` out 1: result available.
- `result_ready` in 1: consumer accepts.
- `result_y`, `result_x` out CORDINATE_WIDTH: coordinates of the defect.
- `result_match` out MATCH_VALUE_WIDTH: captured match value for that defect.
- `result_last` out 1: asserted with the final defect of the round.
- `done` out 1: one-cycle end-of-round pulse.
- `busy` out 1: high in every state except IDLE.

## Operation
- States: IDLE → LOAD → SETTLE → START → OFFER → STOP → CAPTURE → DRAIN → IDLE.
- IDLE: `syndrome_ready`=1. When `syndrome_valid` and `syndrome_ready` are both high:
  - latch `syndrome_in` into `measurement_value_out` and into the pending mask;
  - go to LOAD.
- While not in IDLE, `syndrome_valid` is ignored.
- LOAD: `measurement_valid_out`=1 for exactly one cycle.
- SETTLE: count SETTLE_CYCLES cycles.
- START: `start_offer`=1 for one cycle.
- OFFER: count OFFER_CYCLES cycles.
- STOP: `stop_offer`=1 for one cycle.
- CAPTURE: register all of `match_value_in`.
- DRAIN:
  - `result_valid` = (pending ≠ 0).
  - The result is the lowest set pending index, decoded to (y, x), with its captured match.
  - On handshake, clear that bit.
  - `result_last` = exactly one pending bit remains.
  - When pending = 0, pulse `done` and return to IDLE. A zero syndrome therefore emits no results: `done` fires in the first DRAIN cycle.
- Counter: a single down-counter shared by SETTLE and OFFER, width $clog2(max(SETTLE_CYCLES, OFFER_CYCLES)+1).
- `measurement_value_out` holds its value until the next accept.
- Reset (asynchronous, valid at any time, including mid-round):
  - state goes to IDLE;
  - all outputs go to 0, except `syndrome_ready`, which is 1;
  - pending mask, counter and captured match values are cleared;
  - no pulse is reissued after reset.

## Timing
- Accept edge at cycle 0 (S = SETTLE_CYCLES, O = OFFER_CYCLES):

| Cycle | Event |
|---|---|
| 1 | `measurement_valid_out` |
| 2 … S+1 | SETTLE |
| S+2 | `start_offer` |
| S+3 … S+O+2 | OFFER |
| S+O+3 | `stop_offer` |
| S+O+4 | CAPTURE |
| S+O+5 | first DRAIN cycle; `result_valid` may be high |

- Throughput: one result per cycle while `result_ready`=1.
- Backpressure: while `result_valid` && !`result_ready`, all result fields stay stable.
- `done` is asserted in the cycle after the final handshake. `syndrome_ready` rises in the cycle after `done`.
- All outputs are registered, except `result_*`, which are decoded combinationally from registered state.

## Structure
- Shared package holds:
  - state encoding (8 states, 3 bits);
  - CORDINATE_WIDTH/MATCH_VALUE_WIDTH defaults;
  - index → (y, x) conversion function.
- One sub-module: `lowest_set_encoder`, an N-bit priority encoder returning index and a `none` flag.

## Test plan
Defaults unless stated (2×3 grid, S=100, O=2500, CW=4). Cycle numbers are relative to the accept edge at cycle 0.
- **Two defects.** `syndrome_in`=6'b000011 accepted at cycle 0; grid returns match {0,1} at (0,0) and {0,0} at (0,1).
  - Expect `measurement_valid_out` at cycle 1, `start_offer` at 102, `stop_offer` at 2603.
  - Expect results (0,0) match 0x01, then (0,1) match 0x00 with `result_last`; `done` one cycle later.
- **Backpressure.** `result_ready` held low for 5 cycles in DRAIN → result fields stable, then the same sequence as above with no loss or duplication.
- **Zero syndrome.** 6'b000000 → offer pulses still issued; no `result_valid`; `done` at cycle 2605.
- **All defects.** 6'b111111 with `result_ready`=1 → six results on consecutive cycles in order (0,0),(0,1),(0,2),(1,0),(1,1),(1,2); `result_last` only on (1,2).
- **Busy ignore.** `syndrome_valid`=1 throughout the round with changing data → only the first word is loaded; `measurement_valid_out` pulses once.
- **Mid-round reset.** `reset` asserted at cycle 1000 (OFFER) →
  - all outputs 0 and `syndrome_ready`=1 immediately;
  - no `stop_offer` after release;
  - a new syndrome is accepted normally.
